// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: sequences M-stage loads/stores onto a req/gnt + rvalid data-memory bus
module dm_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [3:0]  m_op,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [3:0] op_q;
  logic [1:0] off_q;
  logic flushed;
  logic ld, st, wd, hw, bt, aligned, req_ok, accept, tmo;
  logic [3:0] be;
  logic [31:0] wrep, sh, ext;
  assign ld = ~m_op[3] & (m_op <= 4'd4);
  assign st = m_op[3] & (m_op[2:0] <= 3'd2);
  assign wd = m_op[2:0] == 3'd0;
  assign hw = (m_op == 4'd3) | (m_op == 4'd4) | (m_op == 4'd10);
  assign bt = (m_op == 4'd1) | (m_op == 4'd2) | (m_op == 4'd9);
  assign aligned = wd ? (m_addr[1:0] == 2'b00) : hw ? ~m_addr[0] : 1'b1;
  assign req_ok = (state == IDLE) & m_valid & ~flush;
  assign accept = req_ok & (ld | st) & aligned;
  assign exc_adel = req_ok & ld & ~aligned;
  assign exc_ades = req_ok & st & ~aligned;
  assign stall = accept | (state == REQ) | (state == WAIT);
  assign bus_req = state == REQ;
  assign tmo = cnt == CNT_W'(TIMEOUT - 1);
  assign be = wd ? 4'hF : hw ? (m_addr[1] ? 4'hC : 4'h3) : 4'b0001 << m_addr[1:0];
  assign wrep = bt ? {4{m_wdata[7:0]}} : hw ? {2{m_wdata[15:0]}} : m_wdata;
  // aligned accesses make a plain right-shift by the byte offset select the right lane
  assign sh = bus_rdata >> {off_q, 3'b000};
  assign ext = op_q == 4'd1 ? {{24{sh[7]}}, sh[7:0]} :
               op_q == 4'd2 ? {24'b0, sh[7:0]} :
               op_q == 4'd3 ? {{16{sh[15]}}, sh[15:0]} :
               op_q == 4'd4 ? {16'b0, sh[15:0]} : bus_rdata;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      off_q <= '0;
      flushed <= 1'b0;
      rdata <= '0;
      rdata_valid <= 1'b0;
      bus_err <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
    end else begin
      rdata_valid <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state <= REQ;
          cnt <= '0;
          op_q <= m_op;
          off_q <= m_addr[1:0];
          flushed <= 1'b0;
          bus_we <= st;
          bus_addr <= {m_addr[31:2], 2'b00};
          bus_be <= be;
          bus_wdata <= wrep;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          flushed <= flushed | flush;
          if (bus_gnt) state <= op_q[3] ? DONE : WAIT;
          else if (tmo) begin
            state <= DONE;
            bus_err <= 1'b1;
            rdata <= '0;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          flushed <= flushed | flush;
          if (bus_rvalid) begin
            state <= DONE;
            rdata <= ext;
            rdata_valid <= ~(flushed | flush);
          end else if (tmo) begin
            state <= DONE;
            bus_err <= 1'b1;
            rdata <= '0;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed self-checking bench for dm_access_ctrl
module tb_dm_access_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic m_valid = 1'b0, flush = 1'b0;
  logic [3:0] m_op = '0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic stall, rdata_valid, exc_adel, exc_ades, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  logic bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  int n_tests = 0, n_fail = 0;
  dm_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_op(m_op), .m_addr(m_addr),
    .m_wdata(m_wdata), .flush(flush), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] d, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    @(negedge clk); m_valid = 1; m_op = op; m_addr = addr; m_wdata = d;
    #1 chk({tag, "_accept_stall"}, stall, 1);
    @(negedge clk); m_valid = 0; bus_gnt = 1;
    #1 chk({tag, "_req"}, bus_req, 1);
    chk({tag, "_stall2"}, stall, 1);
    chk({tag, "_we"}, bus_we, 1);
    chk({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
    chk({tag, "_be"}, bus_be, exp_be);
    chk({tag, "_wdata"}, bus_wdata, exp_wd);
    @(negedge clk); bus_gnt = 0;
    #1 chk({tag, "_done_stall"}, stall, 0);
    chk({tag, "_done_req"}, bus_req, 0);
    chk({tag, "_no_rv"}, rdata_valid, 0);
  endtask
  task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] d, input logic fl, input logic [3:0] exp_be,
                          input logic [31:0] exp_d, input logic exp_v);
    @(negedge clk); m_valid = 1; m_op = op; m_addr = addr;
    #1 chk({tag, "_accept_stall"}, stall, 1);
    @(negedge clk); m_valid = 0;
    #1 chk({tag, "_req"}, bus_req, 1);
    chk({tag, "_we"}, bus_we, 0);
    chk({tag, "_be"}, bus_be, exp_be);
    bus_gnt = 1;
    @(negedge clk); bus_gnt = 0; flush = fl;
    #1 chk({tag, "_wait_req"}, bus_req, 0);
    chk({tag, "_wait_stall"}, stall, 1);
    @(negedge clk); flush = 0; bus_rvalid = 1; bus_rdata = d;
    @(negedge clk); bus_rvalid = 0;
    #1 chk({tag, "_rv"}, rdata_valid, exp_v);
    chk({tag, "_rdata"}, rdata, exp_d);
    chk({tag, "_done_stall"}, stall, 0);
    @(negedge clk);
    #1 chk({tag, "_rv_pulse"}, rdata_valid, 0);
  endtask
  task automatic run_timeout(input string tag, input logic gnt_last);
    int bad = 0;
    @(negedge clk); m_valid = 1; m_op = 4'd8; m_addr = 32'h40; m_wdata = 32'h5;
    @(negedge clk); m_valid = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) bus_gnt = gnt_last;
      #1 if (bus_req !== 1'b1 || bus_err !== 1'b0 || stall !== 1'b1) bad++;
      @(negedge clk);
    end
    bus_gnt = 0;
    #1 chk({tag, "_req_cycles_bad"}, bad, 0);
    chk({tag, "_err"}, bus_err, !gnt_last);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_req_drop"}, bus_req, 0);
    chk({tag, "_rv"}, rdata_valid, 0);
    @(negedge clk);
    #1 chk({tag, "_err_pulse"}, bus_err, 0);
  endtask
  initial begin
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_rv", rdata_valid, 0);
    @(negedge clk); reset = 1;
    run_store("sw", 4'd8, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);
    run_store("sh", 4'd10, 32'h0000_0012, 32'h0000_1234, 4'hC, 32'h1234_1234);
    run_store("sb", 4'd9, 32'h0000_0013, 32'h0000_00AB, 4'h8, 32'hABAB_ABAB);
    run_load("lb", 4'd1, 32'h2003, 32'h80FF_0000, 0, 4'h8, 32'hFFFF_FF80, 1);
    run_load("lbu", 4'd2, 32'h2003, 32'h80FF_0000, 0, 4'h8, 32'h0000_0080, 1);
    run_load("lh", 4'd3, 32'h2002, 32'h80FF_0000, 0, 4'hC, 32'hFFFF_80FF, 1);
    run_load("lhu", 4'd4, 32'h2000, 32'h1234_8765, 0, 4'h3, 32'h0000_8765, 1);
    run_load("lw", 4'd0, 32'h2004, 32'hCAFE_F00D, 0, 4'hF, 32'hCAFE_F00D, 1);
    run_load("lw_flush", 4'd0, 32'h2008, 32'h1111_2222, 1, 4'hF, 32'h1111_2222, 0);
    @(negedge clk); m_valid = 1; m_op = 4'd0; m_addr = 32'h2;
    #1 chk("lw_mis_adel", exc_adel, 1);
    chk("lw_mis_ades", exc_ades, 0);
    chk("lw_mis_stall", stall, 0);
    m_op = 4'd3; m_addr = 32'h1;
    #1 chk("lh_mis_adel", exc_adel, 1);
    m_op = 4'd8; m_addr = 32'h1;
    #1 chk("sw_mis_ades", exc_ades, 1);
    chk("sw_mis_adel", exc_adel, 0);
    flush = 1;
    #1 chk("flush_ades", exc_ades, 0);
    m_op = 4'd8; m_addr = 32'h4;
    #1 chk("flush_no_accept", stall, 0);
    @(negedge clk); m_valid = 0; flush = 0;
    #1 chk("mis_no_req", bus_req, 0);
    run_timeout("tmo", 0);
    run_timeout("gnt_at_limit", 1);
    @(negedge clk); m_valid = 1; m_op = 4'd8; m_addr = 32'h80;
    @(negedge clk); m_valid = 0;
    #1 chk("rst_mid_req_pre", bus_req, 1);
    reset = 0;
    #1 chk("rst_mid_req", bus_req, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_be", bus_be, 0);
    @(negedge clk); reset = 1;
    @(negedge clk);
    #1 chk("rst_idle_req", bus_req, 0);
    chk("rst_idle_err", bus_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
